// File: rtl/data_mem_ctrl.sv
// -----------------------------------------------------------------------------
// data_mem_ctrl
//
// Data-memory controller for the load/store path. Takes a byte address from
// the ALU and store data from the register file, performs byte / halfword /
// word accesses against an internal word array after a fixed number of wait
// states, and presents the sign- or zero-extended load word to the
// write-back select. Stall holds the processor until the access completes.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   MemRead      load request
//   MemWrite     store request
//   Funct3[2:0]  access type: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU
//   Address[31:0]    byte address
//   StoreData[31:0]  store data (low bits used for byte/halfword stores)
//   MemData[31:0]    registered load result, held until the next good load
//   MemReady     one-cycle completion pulse
//   Stall        combinational processor hold
//   AccessFault  one-cycle fault pulse, coincident with MemReady
// -----------------------------------------------------------------------------
module data_mem_ctrl #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  Funct3,
    input  logic [31:0] Address,
    input  logic [31:0] StoreData,
    output logic [31:0] MemData,
    output logic        MemReady,
    output logic        Stall,
    output logic        AccessFault
);

    localparam int          AW    = $clog2(DEPTH_WORDS);
    localparam int          CW    = $clog2(WAIT_CYCLES + 2);
    localparam logic [31:0] LIMIT = 32'(DEPTH_WORDS * 4);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    state_t state;
    state_t next_state;

    logic [CW-1:0] count;
    logic          rd_q;
    logic          wr_q;
    logic          fault_q;
    logic [2:0]    funct3_q;
    logic [AW+1:0] addr_q;
    logic [31:0]   sdata_q;

    logic [31:0] mem [DEPTH_WORDS];

    // -------------------------------------------------------------------------
    // Helper functions
    // -------------------------------------------------------------------------
    function automatic logic access_fault(input logic        is_store,
                                          input logic [2:0]  f3,
                                          input logic [31:0] a);
        logic bad_f3;
        logic misalign;
        logic range_err;
        bad_f3    = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111) ||
                    (is_store && f3[2]);
        misalign  = ((f3[1:0] == 2'b01) && a[0]) ||
                    ((f3[1:0] == 2'b10) && (a[1:0] != 2'b00));
        range_err = (a >= LIMIT);
        return bad_f3 || misalign || range_err;
    endfunction

    // Little-endian lane select followed by sign or zero extension.
    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [2:0]  f3,
                                                input logic [1:0]  lane);
        logic        [7:0]  b;
        logic        [15:0] h;
        logic signed [7:0]  sb;
        logic signed [15:0] sh;
        logic signed [31:0] ext;
        b  = word[{lane, 3'b000} +: 8];
        h  = lane[1] ? word[31:16] : word[15:0];
        sb = signed'(b);
        sh = signed'(h);
        case (f3)
            3'b000:  ext = 32'(sb);
            3'b001:  ext = 32'(sh);
            3'b100:  ext = signed'({24'b0, b});
            3'b101:  ext = signed'({16'b0, h});
            default: ext = signed'(word);
        endcase
        return unsigned'(ext);
    endfunction

    // Replicate the store data across lanes and keep only the addressed ones.
    function automatic logic [31:0] store_merge(input logic [31:0] old,
                                                input logic [31:0] data,
                                                input logic [2:0]  f3,
                                                input logic [1:0]  lane);
        logic [3:0]  mask;
        logic [31:0] wide;
        logic [31:0] res;
        case (f3[1:0])
            2'b00: begin
                mask = 4'b0001 << lane;
                wide = {4{data[7:0]}};
            end
            2'b01: begin
                mask = lane[1] ? 4'b1100 : 4'b0011;
                wide = {2{data[15:0]}};
            end
            default: begin
                mask = 4'b1111;
                wide = data;
            end
        endcase
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = mask[i] ? wide[8*i +: 8] : old[8*i +: 8];
        end
        return res;
    endfunction

    // -------------------------------------------------------------------------
    // Request decode from the live inputs (only meaningful in IDLE)
    // -------------------------------------------------------------------------
    logic req_any;
    logic req_rd;
    logic req_wr;
    logic req_fault;

    assign req_any   = MemRead | MemWrite;
    assign req_rd    = MemRead & ~MemWrite;
    assign req_wr    = MemWrite & ~MemRead;
    assign req_fault = (MemRead & MemWrite) | access_fault(MemWrite, Funct3, Address);

    // With zero wait states the access completes on its own capture edge, so
    // the live inputs stand in for the captured copy while in IDLE.
    logic          eff_rd;
    logic          eff_wr;
    logic          eff_fault;
    logic [2:0]    eff_f3;
    logic [AW+1:0] eff_addr;
    logic [31:0]   eff_sdata;
    logic [AW-1:0] eff_idx;

    always_comb begin
        if (state == IDLE) begin
            eff_rd    = req_rd;
            eff_wr    = req_wr;
            eff_fault = req_fault;
            eff_f3    = Funct3;
            eff_addr  = Address[AW+1:0];
            eff_sdata = StoreData;
        end else begin
            eff_rd    = rd_q;
            eff_wr    = wr_q;
            eff_fault = fault_q;
            eff_f3    = funct3_q;
            eff_addr  = addr_q;
            eff_sdata = sdata_q;
        end
    end

    assign eff_idx = eff_addr[AW+1:2];

    logic enter_done;
    logic commit;
    logic load_upd;

    assign enter_done = (next_state == DONE) && (state != DONE);
    assign commit     = enter_done && eff_wr && !eff_fault && !reset;
    assign load_upd   = enter_done && eff_rd && !eff_fault;

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state and Stall
    // -------------------------------------------------------------------------
    always_comb begin
        next_state = state;
        Stall      = 1'b0;
        case (state)
            IDLE: begin
                Stall = req_any;
                if (req_any) begin
                    next_state = (WAIT_CYCLES == 0) ? DONE : WAIT;
                end
            end
            WAIT: begin
                Stall = 1'b1;
                if (count == CW'(1)) begin
                    next_state = DONE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // Control registers: counter, request flags, completion pulses, load word
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count       <= '0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            fault_q     <= 1'b0;
            MemReady    <= 1'b0;
            AccessFault <= 1'b0;
            MemData     <= '0;
        end else begin
            MemReady    <= enter_done;
            AccessFault <= enter_done && eff_fault;
            if (state == IDLE && req_any) begin
                count   <= CW'(WAIT_CYCLES);
                rd_q    <= req_rd;
                wr_q    <= req_wr;
                fault_q <= req_fault;
            end else if (state == WAIT) begin
                count <= count - CW'(1);
            end
            if (load_upd) begin
                MemData <= load_extend(mem[eff_idx], eff_f3, eff_addr[1:0]);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Captured request payload
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (state == IDLE && req_any) begin
            funct3_q <= Funct3;
            addr_q   <= Address[AW+1:0];
            sdata_q  <= StoreData;
        end
    end

    // -------------------------------------------------------------------------
    // Word array: lane-masked store commit on the edge entering DONE
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (commit) begin
            mem[eff_idx] <= store_merge(mem[eff_idx], eff_sdata, eff_f3, eff_addr[1:0]);
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
module tb_data_mem_ctrl;

    logic        clk;
    logic        reset;

    // Default build (WAIT_CYCLES = 2)
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] address;
    logic [31:0] store_data;
    logic [31:0] mem_data;
    logic        mem_ready;
    logic        stall;
    logic        access_fault;

    // Zero-wait build
    logic        mem_read0;
    logic        mem_write0;
    logic [2:0]  funct3_0;
    logic [31:0] address0;
    logic [31:0] store_data0;
    logic [31:0] mem_data0;
    logic        mem_ready0;
    logic        stall0;
    logic        access_fault0;

    int checks;
    int failures;

    data_mem_ctrl #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut (
        .clk(clk), .reset(reset),
        .MemRead(mem_read), .MemWrite(mem_write), .Funct3(funct3),
        .Address(address), .StoreData(store_data),
        .MemData(mem_data), .MemReady(mem_ready), .Stall(stall),
        .AccessFault(access_fault)
    );

    data_mem_ctrl #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset),
        .MemRead(mem_read0), .MemWrite(mem_write0), .Funct3(funct3_0),
        .Address(address0), .StoreData(store_data0),
        .MemData(mem_data0), .MemReady(mem_ready0), .Stall(stall0),
        .AccessFault(access_fault0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output view of whichever instance the current access targets
    logic        sel;
    logic [31:0] o_data;
    logic        o_ready;
    logic        o_stall;
    logic        o_fault;
    assign o_data  = sel ? mem_data0     : mem_data;
    assign o_ready = sel ? mem_ready0    : mem_ready;
    assign o_stall = sel ? stall0        : stall;
    assign o_fault = sel ? access_fault0 : access_fault;

    // Results of the most recent access
    int          lat;
    int          stl;
    logic        flt;
    logic        stall_done;
    logic        rdy_after;
    logic [31:0] data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request, scramble the inputs right after capture, and measure
    // latency (edges from capture to MemReady, capture edge included) and the
    // number of sampled cycles with Stall high.
    task automatic access(input logic s, input logic rd, input logic wr,
                          input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] sd);
        @(negedge clk);
        sel = s;
        if (s) begin
            mem_read0 = rd; mem_write0 = wr; funct3_0 = f3; address0 = a; store_data0 = sd;
        end else begin
            mem_read = rd; mem_write = wr; funct3 = f3; address = a; store_data = sd;
        end
        #1;
        stl = 0;
        if (o_stall) stl++;
        @(posedge clk);
        #1;
        if (s) begin
            mem_read0 = 1'b0; mem_write0 = 1'b0; funct3_0 = 3'b111;
            address0 = 32'hFFFF_FFFC; store_data0 = ~sd;
        end else begin
            mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'b111;
            address = 32'hFFFF_FFFC; store_data = ~sd;
        end
        lat = 1;
        while (!o_ready && lat < 16) begin
            if (o_stall) stl++;
            @(posedge clk);
            #1;
            lat++;
        end
        flt        = o_fault;
        stall_done = o_stall;
        data       = o_data;
        @(posedge clk);
        #1;
        rdy_after = o_ready;
    endtask

    initial begin
        checks = 0; failures = 0; sel = 1'b0;
        mem_read = 0; mem_write = 0; funct3 = 0; address = 0; store_data = 0;
        mem_read0 = 0; mem_write0 = 0; funct3_0 = 0; address0 = 0; store_data0 = 0;
        reset = 1'b1;
        #1;
        check("rst_memdata",  mem_data,     32'h0);
        check("rst_ready",    {31'b0, mem_ready},    32'h0);
        check("rst_fault",    {31'b0, access_fault}, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_stall",    {31'b0, stall},        32'h0);
        check("rst_memdata2", mem_data,     32'h0);

        // Word store then load, with timing
        access(0, 0, 1, 3'b010, 32'h10, 32'hDEAD_BEEF);
        check("sw_lat",        lat, 3);
        check("sw_stall",      stl, 3);
        check("sw_fault",      {31'b0, flt}, 0);
        check("sw_stall_done", {31'b0, stall_done}, 0);
        check("sw_ready_pulse", {31'b0, rdy_after}, 0);
        access(0, 1, 0, 3'b010, 32'h10, 32'h0);
        check("lw_10", data, 32'hDEAD_BEEF);
        check("lw_lat", lat, 3);

        // Byte store into a zeroed word
        access(0, 0, 1, 3'b010, 32'h20, 32'h0);
        access(0, 0, 1, 3'b000, 32'h21, 32'hFFFF_FFA5);
        access(0, 1, 0, 3'b010, 32'h20, 32'h0);
        check("lw_20", data, 32'h0000_A500);
        access(0, 1, 0, 3'b000, 32'h21, 32'h0);
        check("lb_21", data, 32'hFFFF_FFA5);
        access(0, 1, 0, 3'b100, 32'h21, 32'h0);
        check("lbu_21", data, 32'h0000_00A5);

        // Halfword store/load and misaligned halfword
        access(0, 0, 1, 3'b010, 32'h30, 32'h0);
        access(0, 0, 1, 3'b001, 32'h32, 32'h1234_8001);
        access(0, 1, 0, 3'b001, 32'h32, 32'h0);
        check("lh_32", data, 32'hFFFF_8001);
        access(0, 1, 0, 3'b101, 32'h32, 32'h0);
        check("lhu_32", data, 32'h0000_8001);
        access(0, 1, 0, 3'b010, 32'h30, 32'h0);
        check("lw_30", data, 32'h8001_0000);
        access(0, 1, 0, 3'b101, 32'h32, 32'h0);
        access(0, 1, 0, 3'b001, 32'h31, 32'h0);
        check("lh_31_fault", {31'b0, flt}, 1);
        check("lh_31_keep",  data, 32'h0000_8001);
        check("lh_31_lat",   lat, 3);

        // Out-of-range store must not alias onto word 0
        access(0, 0, 1, 3'b010, 32'h0, 32'h0);
        access(0, 0, 1, 3'b010, 32'h400, 32'h1111_1111);
        check("sw_400_fault", {31'b0, flt}, 1);
        access(0, 1, 0, 3'b010, 32'h0, 32'h0);
        check("sw_400_nowrite", data, 32'h0);
        check("lw_0_nofault",   {31'b0, flt}, 0);

        // Both strobes, undefined store type, misaligned word
        access(0, 1, 1, 3'b010, 32'h10, 32'h0);
        check("both_fault", {31'b0, flt}, 1);
        check("both_lat",   lat, 3);
        access(0, 0, 1, 3'b100, 32'h10, 32'h0);
        check("sbu_fault", {31'b0, flt}, 1);
        access(0, 1, 0, 3'b010, 32'h12, 32'h0);
        check("lw_12_fault", {31'b0, flt}, 1);
        access(0, 1, 0, 3'b011, 32'h10, 32'h0);
        check("ld_011_fault", {31'b0, flt}, 1);
        access(0, 1, 0, 3'b010, 32'h10, 32'h0);
        check("lw_10_intact", data, 32'hDEAD_BEEF);

        // Reset during WAIT abandons the store
        access(0, 0, 1, 3'b010, 32'h40, 32'hCAFE_F00D);
        @(negedge clk);
        sel = 1'b0;
        mem_write = 1'b1; funct3 = 3'b010; address = 32'h40; store_data = 32'h1234_5678;
        @(posedge clk);
        #1;
        mem_write = 1'b0;
        check("wait_stall", {31'b0, stall}, 1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_mid_stall", {31'b0, stall}, 0);
        check("rst_mid_ready", {31'b0, mem_ready}, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_mid_stall2", {31'b0, stall}, 0);
        access(0, 1, 0, 3'b010, 32'h40, 32'h0);
        check("lw_40_old", data, 32'hCAFE_F00D);

        // Zero-wait build
        access(1, 0, 1, 3'b010, 32'h8, 32'hA1B2_C3D4);
        check("w0_sw_lat",   lat, 1);
        check("w0_sw_stall", stl, 1);
        check("w0_sw_ready_pulse", {31'b0, rdy_after}, 0);
        access(1, 1, 0, 3'b010, 32'h8, 32'h0);
        check("w0_lw_8",  data, 32'hA1B2_C3D4);
        check("w0_lw_lat", lat, 1);
        access(1, 1, 0, 3'b101, 32'hA, 32'h0);
        check("w0_lhu_a", data, 32'h0000_A1B2);
        access(1, 1, 0, 3'b000, 32'hB, 32'h0);
        check("w0_lb_b",  data, 32'hFFFF_FFA1);
        access(1, 0, 1, 3'b010, 32'h9, 32'h0);
        check("w0_sw_mis_fault", {31'b0, flt}, 1);
        access(1, 1, 0, 3'b010, 32'h8, 32'h0);
        check("w0_lw_8_intact", data, 32'hA1B2_C3D4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
